// File: rtl/xor_frame_decoder.sv
// xor_frame_decoder: descrambles XOR-keyed data bytes into a one-entry output
// buffer and checks each frame's trailing plaintext parity byte.
// Optional build macro: XOR_ROLL_KEY_EN (per-byte rotating key, reloaded each frame).
module xor_frame_decoder #(
  parameter int unsigned FRAME_LEN = 4,
  parameter logic [7:0]  KEY       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] byte_cnt
);

  localparam int unsigned W = 8;
  localparam logic [W-1:0] LAST_IDX = W'(FRAME_LEN - 1);

  typedef enum logic {
    DATA = 1'b0,
    CHK  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] acc;
  logic [W-1:0] acc_nxt;
  logic [W-1:0] out_data_nxt;
  logic [W-1:0] byte_cnt_nxt;
  logic [W-1:0] cur_key;
  logic [W-1:0] plain;
  logic         out_valid_nxt;
  logic         out_last_nxt;
  logic         frame_done_nxt;
  logic         frame_err_nxt;
  logic         accept;

`ifdef XOR_ROLL_KEY_EN
  logic [W-1:0] key_q;
  logic [W-1:0] key_nxt;
  assign cur_key = key_q;
`else
  assign cur_key = KEY;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and datapath next values
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_last_nxt   = out_last;
    byte_cnt_nxt   = byte_cnt;
    frame_done_nxt = 1'b0;
    frame_err_nxt  = frame_err;
    in_ready       = 1'b0;
    accept         = 1'b0;
    plain          = in_data ^ cur_key;
`ifdef XOR_ROLL_KEY_EN
    key_nxt        = key_q;
`endif

    // Drain first; a same-cycle data accept below reloads the buffer
    if (out_valid && out_ready) begin
      out_valid_nxt = 1'b0;
    end

    case (state)
      DATA: begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          out_data_nxt  = plain;
          out_valid_nxt = 1'b1;
          acc_nxt       = acc ^ plain;
`ifdef XOR_ROLL_KEY_EN
          key_nxt       = {key_q[W-2:0], key_q[W-1]};
`endif
          if (byte_cnt == LAST_IDX) begin
            out_last_nxt = 1'b1;
            byte_cnt_nxt = '0;
            state_nxt    = CHK;
          end else begin
            out_last_nxt = 1'b0;
            byte_cnt_nxt = byte_cnt + W'(1);
          end
        end
      end
      CHK: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          frame_err_nxt  = (acc != in_data);
          frame_done_nxt = 1'b1;
          acc_nxt        = '0;
          state_nxt      = DATA;
`ifdef XOR_ROLL_KEY_EN
          key_nxt        = KEY;
`endif
        end
      end
      default: begin
        state_nxt = DATA;
      end
    endcase
  end

  // Output buffer, parity accumulator and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt   <= '0;
      acc        <= '0;
    end else begin
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_last   <= out_last_nxt;
      frame_done <= frame_done_nxt;
      frame_err  <= frame_err_nxt;
      byte_cnt   <= byte_cnt_nxt;
      acc        <= acc_nxt;
    end
  end

`ifdef XOR_ROLL_KEY_EN
  // Rolling key register, reloaded at reset and at each frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= KEY;
    end else begin
      key_q <= key_nxt;
    end
  end
`endif

endmodule

// File: doc/xor_frame_decoder.md
Name: xor_frame_decoder

Overview:
Receive-side counterpart of the team's XOR encoding logic. Accepts a byte stream of XOR-scrambled frames, recovers each plaintext byte by XOR with a key, and forwards it through a one-entry output buffer. Checks each frame's trailing parity byte against the running XOR of the decoded bytes. Sits between the link input and downstream byte consumers, with valid/ready on both sides.

Parameters:
FRAME_LEN, 4, data bytes per frame (legal range 1..255); parity byte not counted
KEY, 8'hA5, XOR key applied to every data byte

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a valid byte
in_ready  output  1  decoder accepts in_data this cycle
in_data  input  8  scrambled data byte, or plain parity byte at frame end
out_valid  output  1  out_data holds a decoded byte
out_ready  input  1  consumer takes out_data this cycle
out_data  output  8  decoded plaintext byte
out_last  output  1  out_data is the last data byte of its frame; qualified by out_valid
frame_done  output  1  one-cycle pulse after the parity byte is accepted
frame_err  output  1  parity mismatch for the most recent frame; held until the next frame_done
byte_cnt  output  8  data bytes accepted so far in the current frame

Behaviour:
- Reset, synchronous on a clk edge with reset=1:
  - state=DATA; out_valid, out_data, out_last, frame_done, frame_err, byte_cnt, acc all 0.
  - Reset overrides any in-progress frame; a partial frame is discarded.
- Accept condition: in_valid && in_ready.
- in_ready is combinational:
  - DATA: in_ready = !out_valid || out_ready.
  - CHK: in_ready = 1.
- DATA state, on accept:
  - out_data <= in_data ^ key; out_valid <= 1; acc <= acc ^ (in_data ^ key); byte_cnt++.
  - If byte_cnt == FRAME_LEN-1: out_last <= 1, byte_cnt <= 0, state <= CHK. Otherwise out_last <= 0.
- Output buffer:
  - out_valid clears on out_valid && out_ready when there is no accept in the same cycle.
  - Drain and accept in the same cycle: the new byte loads and out_valid stays 1. No bubble, no loss.
  - out_data and out_last are stable while out_valid && !out_ready.
- CHK state, on accept:
  - in_data is the parity byte (plaintext XOR of the frame's data bytes, sent unscrambled). It is not forwarded.
  - frame_err <= (acc != in_data); frame_done <= 1 for exactly one cycle; acc <= 0; state <= DATA.
  - The output buffer may still hold the last data byte while in CHK; it drains normally.
- Latency: one cycle from data accept to out_valid, and from parity accept to frame_done.
- Width rules: all datapath is 8-bit XOR; no carries. byte_cnt wraps only through the FRAME_LEN compare.
- FRAME_LEN=1: every data byte has out_last=1 and is followed by a parity byte.

Optional Feature:
XOR_ROLL_KEY_EN
- Defined: the key is an 8-bit register loaded with KEY at reset and at every frame start (CHK->DATA). It rotates left by 1 after each accepted data byte, so byte i of a frame uses KEY rotated left by i.
- Undefined: the key is the constant KEY for every byte. No key register is synthesized.

Test Plan:
1. KEY=A5, FRAME_LEN=4, out_ready=1; in A4,A7,A6,A1 then parity 04 -> out 01,02,03,04, out_last only on 04; frame_done pulse with frame_err=0.
2. Same data bytes, parity 05 -> frame_done with frame_err=1; frame_err stays 1 until the next frame_done; the next good frame clears it to 0.
3. Backpressure: out_ready=0 after first accept -> out_data held at 01, in_ready=0, in_data A7 not consumed; raise out_ready -> 02 follows with no loss or duplication.
4. Simultaneous drain+accept with in_valid=1 and out_ready=1 every cycle -> one byte per cycle, out_valid continuously 1 across the 4 data bytes.
5. Reset asserted after 2 data bytes of a frame -> all outputs 0, byte_cnt=0; a fresh frame A4,A7,A6,A1 + parity 04 -> frame_err=0.
6. With XOR_ROLL_KEY_EN defined: in A5,4B,96,2D, parity 00 -> out 00,00,00,00 with frame_err=0; a second identical frame also decodes to 00s, confirming the key reloads at frame start.
